ctrl_unit: RTL and testbench

Hardwired control FSM that sequences the existing single-bus datapath (PC, IR, MAR/MDR, Y, Z-hi/lo, HI/LO, R0-R15).
- Fetches each instruction (T0-T2), decodes IR, then drives the register/ALU strobes for reg-reg ALU and mul/div instructions.
- Replaces the per-instruction hand-sequenced strobe stimulus; its outputs connect 1:1 to the datapath control inputs.

---
 rtl/ctrl_unit_if.sv | 30 +++
 rtl/ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_ctrl_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_unit_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath.
interface ctrl_unit_if;
  logic        Run;
  logic        MemReady;
  logic [31:0] IR;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, Read;
  logic        IRin, Yin;
  logic        ZLowin, ZHighin, ZLowout, ZHighout;
  logic        HIin, LOin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  OP;
  logic        Busy, Halted, Illegal, MemFault;
  logic [31:0] InstrCount;

  modport master (
    input  Run, MemReady, IR,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
           ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Rin, Rout, OP,
           Busy, Halted, Illegal, MemFault, InstrCount
  );

  modport slave (
    output Run, MemReady, IR,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
           ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Rin, Rout, OP,
           Busy, Halted, Illegal, MemFault, InstrCount
  );
endinterface

// File: rtl/ctrl_unit.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath; strobes decode from state.
// Optional retired-instruction counter enabled by INSTR_COUNT_EN (InstrCount tied to 0 otherwise).
module ctrl_unit #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic         Clock,
  input  logic         Clear,
  ctrl_unit_if.master  cu
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
  } state_t;

  localparam logic [4:0] OPC_NOP  = 5'b11000;
  localparam logic [4:0] OPC_HALT = 5'b11001;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       illegal;
  logic       mem_fault;
  logic [4:0] opc;
  logic       is_alu;
  logic       is_md;

  assign opc   = cu.IR[31:27];
  assign is_md = (opc == 5'b01110) || (opc == 5'b01111);

  always_comb begin
    case (opc)
      5'b00101, 5'b00110, 5'b00011, 5'b00100,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: is_alu = 1'b1;
      default:                                is_alu = 1'b0;
    endcase
  end

  function automatic logic [4:0] op_map(input logic [4:0] o);
    case (o)
      5'b00101: op_map = 5'b00000;
      5'b00110: op_map = 5'b00001;
      5'b00011: op_map = 5'b00010;
      5'b00100: op_map = 5'b00011;
      5'b00111: op_map = 5'b00100;
      5'b01000: op_map = 5'b00101;
      5'b01001: op_map = 5'b00110;
      5'b01010: op_map = 5'b00111;
      5'b01110: op_map = 5'b01000;
      5'b01111: op_map = 5'b01001;
      default:  op_map = 5'b00000;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cu.Run) state <= T0;
        T0:   state <= T1;
        T1: begin
          if (cu.MemReady) begin
            wait_cnt <= 8'd0;
            state    <= T2;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= 8'd0;
            mem_fault <= 1'b1;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        T2: state <= T3;
        T3: begin
          if (is_alu || is_md)      state <= T4;
          else if (opc == OPC_HALT) state <= HALT;
          else begin
            // NOP and illegal opcodes both fall to the instruction boundary
            if (opc != OPC_NOP) illegal <= 1'b1;
            state <= cu.Run ? T0 : IDLE;
          end
        end
        T4: state <= T5;
        T5: if (is_md) state <= T6;
            else       state <= cu.Run ? T0 : IDLE;
        T6:   state <= cu.Run ? T0 : IDLE;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cu.PCout = 1'b0; cu.PCin = 1'b0; cu.IncPC = 1'b0;
    cu.MARin = 1'b0; cu.MDRin = 1'b0; cu.MDRout = 1'b0; cu.Read = 1'b0;
    cu.IRin = 1'b0; cu.Yin = 1'b0;
    cu.ZLowin = 1'b0; cu.ZHighin = 1'b0; cu.ZLowout = 1'b0; cu.ZHighout = 1'b0;
    cu.HIin = 1'b0; cu.LOin = 1'b0;
    cu.Rin = 16'd0; cu.Rout = 16'd0; cu.OP = 5'd0;
    case (state)
      T0: begin
        cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1;
        cu.ZLowin = 1'b1; cu.ZHighin = 1'b1;
      end
      T1: begin
        cu.Read = 1'b1; cu.MDRin = 1'b1;
        if (cu.MemReady) begin
          cu.ZLowout = 1'b1; cu.PCin = 1'b1;
        end
      end
      T2: begin
        cu.MDRout = 1'b1; cu.IRin = 1'b1;
      end
      T3: if (is_alu || is_md) begin
        cu.Rout = 16'd1 << cu.IR[22:19];
        cu.Yin  = 1'b1;
      end
      T4: begin
        cu.Rout    = 16'd1 << cu.IR[18:15];
        cu.OP      = op_map(opc);
        cu.ZLowin  = 1'b1;
        cu.ZHighin = 1'b1;
      end
      T5: begin
        cu.ZLowout = 1'b1;
        if (is_md) cu.LOin = 1'b1;
        else       cu.Rin  = 16'd1 << cu.IR[26:23];
      end
      T6: begin
        cu.ZHighout = 1'b1; cu.HIin = 1'b1;
      end
      default: ;
    endcase
  end

  assign cu.Busy     = (state != IDLE) && (state != HALT);
  assign cu.Halted   = (state == HALT);
  assign cu.Illegal  = illegal;
  assign cu.MemFault = mem_fault;

`ifdef INSTR_COUNT_EN
  logic        retire;
  logic [31:0] instr_cnt;

  assign retire = ((state == T3) && ((opc == OPC_NOP) || (opc == OPC_HALT)))
               || ((state == T5) && !is_md)
               ||  (state == T6);

  always_ff @(posedge Clock) begin
    if (!Clear)      instr_cnt <= 32'd0;
    else if (retire) instr_cnt <= instr_cnt + 32'd1;
  end

  assign cu.InstrCount = instr_cnt;
`else
  assign cu.InstrCount = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit with a small behavioural datapath driven by its strobes.
module tb_ctrl_unit;

  logic Clock;
  logic Clear;
  ctrl_unit_if cu ();

  ctrl_unit #(.MEM_WAIT_MAX(15)) dut (.Clock(Clock), .Clear(Clear), .cu(cu));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

`ifdef INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [14:0] B_PCOUT = 15'h4000, B_PCIN  = 15'h2000, B_INCPC = 15'h1000;
  localparam logic [14:0] B_MARIN = 15'h0800, B_MDRIN = 15'h0400, B_MDROUT = 15'h0200;
  localparam logic [14:0] B_READ  = 15'h0100, B_IRIN  = 15'h0080, B_YIN   = 15'h0040;
  localparam logic [14:0] B_ZLIN  = 15'h0020, B_ZHIN  = 15'h0010, B_ZLOUT = 15'h0008;
  localparam logic [14:0] B_ZHOUT = 15'h0004, B_HIIN  = 15'h0002, B_LOIN  = 15'h0001;
  localparam logic [14:0] S_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN | B_ZHIN;
  localparam logic [14:0] S_T1 = B_READ | B_MDRIN | B_ZLOUT | B_PCIN;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural datapath: one shared bus, registers loaded by the DUT strobes.
  logic [31:0] regs [16];
  logic [31:0] pc, y, zlo, zhi, hi, lo, bus;

  function automatic int oh_idx(input logic [15:0] v);
    oh_idx = 0;
    for (int i = 15; i >= 0; i--) if (v[i]) oh_idx = i;
  endfunction

  always_comb begin
    bus = 32'd0;
    if (cu.PCout)           bus = pc;
    else if (cu.ZLowout)    bus = zlo;
    else if (cu.ZHighout)   bus = zhi;
    else if (cu.Rout != 0)  bus = regs[oh_idx(cu.Rout)];
  end

  always @(posedge Clock) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      regs[2] <= 32'h14;
      regs[3] <= 32'h18;
      pc <= 32'd0; y <= 32'd0; zlo <= 32'd0; zhi <= 32'd0; hi <= 32'd0; lo <= 32'd0;
    end else begin
      if (cu.Yin) y <= bus;
      if (cu.ZLowin) begin
        if (cu.IncPC)               begin zlo <= bus + 32'd1; zhi <= 32'd0; end
        else if (cu.OP == 5'd0)     begin zlo <= y & bus;     zhi <= 32'd0; end
        else if (cu.OP == 5'd2)     begin zlo <= y + bus;     zhi <= 32'd0; end
        else if (cu.OP == 5'd8)     {zhi, zlo} <= 64'(y) * 64'(bus);
        else                        begin zlo <= 32'd0;       zhi <= 32'd0; end
      end
      if (cu.PCin) pc <= bus;
      if (cu.Rin != 0) regs[oh_idx(cu.Rin)] <= bus;
      if (cu.LOin) lo <= bus;
      if (cu.HIin) hi <= bus;
    end
  end

  function automatic logic [51:0] obs();
    obs = {cu.PCout, cu.PCin, cu.IncPC, cu.MARin, cu.MDRin, cu.MDRout, cu.Read,
           cu.IRin, cu.Yin, cu.ZLowin, cu.ZHighin, cu.ZLowout, cu.ZHighout,
           cu.HIin, cu.LOin, cu.Rin, cu.Rout, cu.OP};
  endfunction

  function automatic logic [51:0] ev(input logic [14:0] s, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic [4:0] op);
    ev = {s, rin, rout, op};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic test_reset();
    Clear = 1'b0; cu.Run = 1'b0; cu.MemReady = 1'b0; cu.IR = 32'd0;
    tick(); tick();
    n_total++;
    if (obs() !== 52'd0) $display("FAIL reset_strobes got %h want 0", obs()); else n_pass++;
    n_total++;
    if ({cu.Busy, cu.Halted, cu.Illegal, cu.MemFault} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {cu.Busy, cu.Halted, cu.Illegal, cu.MemFault});
    else n_pass++;
    n_total++;
    if (cu.InstrCount !== 32'd0) $display("FAIL reset_count got %h want 0", cu.InstrCount); else n_pass++;
    Clear = 1'b1;
    tick();
  endtask

  task automatic test_and();
    logic [51:0] e [6];
    e = '{ev(S_T0, 0, 0, 0), ev(S_T1, 0, 0, 0), ev(B_MDROUT | B_IRIN, 0, 0, 0),
          ev(B_YIN, 0, 16'h0004, 0), ev(B_ZLIN | B_ZHIN, 0, 16'h0008, 5'b00000),
          ev(B_ZLOUT, 16'h0002, 0, 0)};
    cu.IR = 32'h28918000; cu.MemReady = 1'b1; cu.Run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (obs() !== e[i]) $display("FAIL and_cycle%0d got %h want %h", i, obs(), e[i]); else n_pass++;
      if (i == 5) cu.Run = 1'b0;
    end
    tick();
    n_total++;
    if (cu.Busy !== 1'b0) $display("FAIL and_idle busy got %b want 0", cu.Busy); else n_pass++;
    n_total++;
    if (regs[1] !== 32'h10) $display("FAIL and_r1 got %h want 00000010", regs[1]); else n_pass++;
    n_total++;
    if (pc !== 32'd1) $display("FAIL and_pc got %h want 00000001", pc); else n_pass++;
    n_total++;
    if (cu.InstrCount !== (CNT_EN ? 32'd1 : 32'd0))
      $display("FAIL and_count got %h want %h", cu.InstrCount, CNT_EN ? 32'd1 : 32'd0);
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [51:0] e [7];
    e = '{ev(S_T0, 0, 0, 0), ev(S_T1, 0, 0, 0), ev(B_MDROUT | B_IRIN, 0, 0, 0),
          ev(B_YIN, 0, 16'h0004, 0), ev(B_ZLIN | B_ZHIN, 0, 16'h0008, 5'b01000),
          ev(B_ZLOUT | B_LOIN, 0, 0, 0), ev(B_ZHOUT | B_HIIN, 0, 0, 0)};
    cu.IR = 32'h71918000; cu.Run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_total++;
      if (obs() !== e[i]) $display("FAIL mul_cycle%0d got %h want %h", i, obs(), e[i]); else n_pass++;
      if (i == 6) cu.Run = 1'b0;
    end
    tick();
    n_total++;
    if ({cu.Busy, hi, lo} !== {1'b0, 32'd0, 32'h1E0})
      $display("FAIL mul_result got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=1e0", cu.Busy, hi, lo);
    else n_pass++;
  endtask

  task automatic test_run_drop();
    cu.IR = 32'h18918000; cu.Run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (obs() !== ev(B_ZLIN | B_ZHIN, 0, 16'h0008, 5'b00010))
      $display("FAIL add_t4 got %h want %h", obs(), ev(B_ZLIN | B_ZHIN, 0, 16'h0008, 5'b00010));
    else n_pass++;
    cu.Run = 1'b0;
    tick();
    n_total++;
    if (obs() !== ev(B_ZLOUT, 16'h0002, 0, 0))
      $display("FAIL add_t5 got %h want %h", obs(), ev(B_ZLOUT, 16'h0002, 0, 0));
    else n_pass++;
    tick(); tick();
    n_total++;
    if ({cu.Busy, obs()} !== 53'd0) $display("FAIL add_idle got %h want 0", {cu.Busy, obs()}); else n_pass++;
    n_total++;
    if (regs[1] !== 32'h2C) $display("FAIL add_r1 got %h want 0000002c", regs[1]); else n_pass++;
    cu.Run = 1'b1;
    tick();
    n_total++;
    if (obs() !== ev(S_T0, 0, 0, 0)) $display("FAIL add_restart got %h want %h", obs(), ev(S_T0, 0, 0, 0));
    else n_pass++;
  endtask

  // Enters mid-T0 of the next instruction from test_run_drop.
  task automatic test_illegal_halt();
    cu.IR = 32'hF8000000;
    tick(); tick(); tick();
    n_total++;
    if ({obs(), cu.Illegal} !== 53'd0) $display("FAIL ill_t3 got %h want 0", {obs(), cu.Illegal}); else n_pass++;
    tick();
    n_total++;
    if ({obs(), cu.Illegal} !== {ev(S_T0, 0, 0, 0), 1'b1})
      $display("FAIL ill_next got %h want %h", {obs(), cu.Illegal}, {ev(S_T0, 0, 0, 0), 1'b1});
    else n_pass++;
    cu.IR = 32'hC8000000;
    tick(); tick(); tick();
    n_total++;
    if ({obs(), cu.Busy} !== {52'd0, 1'b1}) $display("FAIL halt_t3 got %h want 1", {obs(), cu.Busy}); else n_pass++;
    tick(); tick();
    n_total++;
    if ({cu.Halted, cu.Busy, cu.Illegal} !== 3'b101)
      $display("FAIL halt_state got %b want 101", {cu.Halted, cu.Busy, cu.Illegal});
    else n_pass++;
    n_total++;
    if (cu.InstrCount !== (CNT_EN ? 32'd4 : 32'd0))
      $display("FAIL halt_count got %h want %h", cu.InstrCount, CNT_EN ? 32'd4 : 32'd0);
    else n_pass++;
  endtask

  task automatic test_memfault();
    int bad;
    Clear = 1'b0; cu.Run = 1'b0;
    tick();
    Clear = 1'b1; cu.MemReady = 1'b0; cu.Run = 1'b1; cu.IR = 32'h28918000;
    tick();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if ({obs(), cu.Busy} !== {ev(B_READ | B_MDRIN, 0, 0, 0), 1'b1}) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL wait_t1 got %0d bad cycles want 0", bad); else n_pass++;
    tick();
    n_total++;
    if ({cu.MemFault, cu.Halted, cu.Busy} !== 3'b110)
      $display("FAIL memfault got %b want 110", {cu.MemFault, cu.Halted, cu.Busy});
    else n_pass++;
    Clear = 1'b0; cu.Run = 1'b0;
    tick();
    n_total++;
    if ({cu.MemFault, cu.Halted} !== 2'b00)
      $display("FAIL memfault_clear got %b want 00", {cu.MemFault, cu.Halted});
    else n_pass++;
    Clear = 1'b1;
  endtask

  task automatic test_clear_mid();
    cu.MemReady = 1'b1; cu.IR = 32'h18918000; cu.Run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (cu.OP !== 5'b00010) $display("FAIL mid_t4_op got %b want 00010", cu.OP); else n_pass++;
    Clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({obs(), cu.Busy, cu.Halted, cu.Illegal, cu.MemFault, cu.InstrCount} !== 88'd0)
        $display("FAIL mid_clear%0d got %h want 0", i,
                 {obs(), cu.Busy, cu.Halted, cu.Illegal, cu.MemFault, cu.InstrCount});
      else n_pass++;
    end
    Clear = 1'b1;
    tick();
    n_total++;
    if (obs() !== ev(S_T0, 0, 0, 0)) $display("FAIL mid_restart got %h want %h", obs(), ev(S_T0, 0, 0, 0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_and();
    test_mul();
    test_run_drop();
    test_illegal_halt();
    test_memfault();
    test_clear_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
